// File: rtl/div_pkg.sv
// Shared types and sizing for the radix-2 iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Iteration counter must hold the value WIDTH itself.
  localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT + 1);

  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_lzc.sv
// Leading-zero counter; all-zero input reports WIDTH. Used only with DIV_RADIX2_EARLY_OUT_EN.
// Latency: combinational.
// Backpressure: none, pure function of data_i.
module div_lzc
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT,
  parameter int CW    = div_cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    lz_o
);

  logic found;

  // Scan from the MSB down; the first set bit fixes the count.
  always_comb begin
    lz_o  = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        lz_o  = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_radix2_iter.sv
// Unsigned restoring radix-2 divider, {quotient, remainder} out; DIV_RADIX2_EARLY_OUT_EN skips dividend leading zeros.
// Latency: accept at T, result strobe at T+N+1 (N = WIDTH, or WIDTH-lz clamped to >=1 with early-out).
// Backpressure: joint ready low from accept until back in IDLE; output strobe cannot be stalled.
module div_radix2_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int CW = div_cnt_width(WIDTH);

  div_state_t         state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;

  logic               accept;
  logic [WIDTH-1:0]   load_quo;
  logic [CW-1:0]      load_n;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;

  assign accept = (state_q == IDLE) && rdy_q &&
                  s_axis_dividend_tvalid && s_axis_divisor_tvalid;

`ifdef DIV_RADIX2_EARLY_OUT_EN
  logic [CW-1:0] lz_raw;
  logic [CW-1:0] lz_eff;

  div_lzc #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_lzc (
    .data_i (s_axis_dividend_tdata),
    .lz_o   (lz_raw)
  );

  // A zero divisor must run every step so the quotient fills with ones.
  assign lz_eff   = (s_axis_divisor_tdata == '0) ? '0 : lz_raw;
  assign load_quo = s_axis_dividend_tdata << lz_eff;
  assign load_n   = (lz_eff == CW'(WIDTH)) ? CW'(1) : (CW'(WIDTH) - lz_eff);
`else
  assign load_quo = s_axis_dividend_tdata;
  assign load_n   = CW'(WIDTH);
`endif

  // One restoring step: shift {rem,quo} left, trial-subtract, keep on borrow.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    step_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d   = '0;
          quo_d   = load_quo;
          dvs_d   = s_axis_divisor_tdata;
          cnt_d   = load_n;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          dout_d  = {step_quo, step_rem};
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Ready is registered so it stays low through reset and rises one edge later.
    rdy_d = (state_d == IDLE);
  end

  // State, datapath and ready registers; async clear discards any in-flight op.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign s_axis_dividend_tready = rdy_q;
  assign s_axis_divisor_tready  = rdy_q;
  assign m_axis_dout_tvalid     = (state_q == DONE);
  assign m_axis_dout_tdata      = dout_q;

endmodule

// File: tb/tb_div_radix2_iter.sv
// Randomized scoreboard bench for div_radix2_iter against a plain-arithmetic model.
// Latency: checks result strobe cycle T+N+1 and ready return at T+N+2.
// Backpressure: drives both operands only when ready is high; output is never stalled.
module tb_div_radix2_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         dvd_vld = 1'b0;
  logic         dvd_rdy;
  logic [W-1:0] dvd_dat = '0;
  logic         dvs_vld = 1'b0;
  logic         dvs_rdy;
  logic [W-1:0] dvs_dat = '0;
  logic         out_vld;
  logic [2*W-1:0] out_dat;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [2*W-1:0] exp_d[$];
  int             exp_t[$];
  logic [2*W-1:0] last_exp = '0;

  div_radix2_iter #(.WIDTH(W)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .s_axis_dividend_tvalid (dvd_vld),
    .s_axis_dividend_tready (dvd_rdy),
    .s_axis_dividend_tdata  (dvd_dat),
    .s_axis_divisor_tvalid  (dvs_vld),
    .s_axis_divisor_tready  (dvs_rdy),
    .s_axis_divisor_tdata   (dvs_dat),
    .m_axis_dout_tvalid     (out_vld),
    .m_axis_dout_tdata      (out_dat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result: ordinary division, divide-by-zero yields all ones / dividend.
  function automatic logic [2*W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Reference step count: full width, or significant dividend bits with early-out.
  function automatic int model_n(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = W;
`ifdef DIV_RADIX2_EARLY_OUT_EN
    if (b != 0) begin
      int sig;
      sig = 0;
      for (int k = 0; k < W; k++) if (a[k]) sig = k + 1;
      n = (sig < 1) ? 1 : sig;
    end
`endif
    return n;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && out_vld) begin
      if (exp_d.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tvalid actual=1 expected=0 data=%h (cycle %0d)", out_dat, cyc);
      end else begin
        logic [2*W-1:0] e;
        int et;
        e  = exp_d.pop_front();
        et = exp_t.pop_front();
        last_exp = e;
        chk("dout", out_dat, e);
        chk("tvalid_cycle", 64'(cyc), 64'(et));
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!dvd_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {63'd0, dvd_rdy}, 64'd1);
  endtask

  // Issue one op at the current negedge (ready high), then watch ready until it returns.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int  n;
    bit  win_ok;
    n = model_n(a, b);
    dvd_dat = a;
    dvs_dat = b;
    dvd_vld = 1'b1;
    dvs_vld = 1'b1;
    exp_d.push_back(model_res(a, b));
    exp_t.push_back(cyc + n + 1);
    @(negedge clk);
    dvd_vld = 1'b0;
    dvs_vld = 1'b0;
    dvd_dat = $urandom;
    dvs_dat = $urandom;
    win_ok = 1'b1;
    for (int i = 1; i <= n + 1; i++) begin
      if (i > 1) @(negedge clk);
      if (dvd_rdy || dvs_rdy) win_ok = 1'b0;
    end
    @(negedge clk);
    chk("ready_window", {62'd0, win_ok, (dvd_rdy & dvs_rdy)}, 64'd3);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit hold_ok;

    // Reset values while rstn is low.
    repeat (2) @(negedge clk);
    chk("rst_ready", {62'd0, dvd_rdy, dvs_rdy}, 64'd0);
    chk("rst_tvalid", {63'd0, out_vld}, 64'd0);
    chk("rst_dout", out_dat, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {62'd0, dvd_rdy, dvs_rdy}, 64'd3);

    // Directed operands.
    issue(32'd100, 32'd7);
    issue(32'hFFFFFFFF, 32'd1);
    issue(32'h12345678, 32'd0);
    issue(32'd5, 32'd3);
    issue(32'd0, 32'd7);
    issue(32'd3, 32'd5);
    issue(32'd0, 32'd0);

    // Only the dividend valid: nothing may be accepted.
    hold_ok = 1'b1;
    dvd_vld = 1'b1;
    dvd_dat = 32'd20;
    repeat (5) begin
      @(negedge clk);
      if (!dvd_rdy || !dvs_rdy) hold_ok = 1'b0;
    end
    chk("single_valid_hold", {63'd0, hold_ok}, 64'd1);
    issue(32'd20, 32'd6);

    // Reset in the middle of 1000/3.
    wait_ready();
    dvd_dat = 32'd1000;
    dvs_dat = 32'd3;
    dvd_vld = 1'b1;
    dvs_vld = 1'b1;
    @(negedge clk);
    dvd_vld = 1'b0;
    dvs_vld = 1'b0;
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_ready", {62'd0, dvd_rdy, dvs_rdy}, 64'd0);
    chk("midrst_tvalid", {63'd0, out_vld}, 64'd0);
    chk("midrst_dout", out_dat, 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_ready_held", {62'd0, dvd_rdy, dvs_rdy}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready_release", {62'd0, dvd_rdy, dvs_rdy}, 64'd3);
    repeat (40) @(negedge clk);
    chk("midrst_dout_idle", out_dat, 64'd0);
    issue(32'd9, 32'd3);

    // Back-to-back randomized operands of varied magnitude.
    for (int j = 0; j < 40; j++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) b = '0;
      else b = $urandom >> $urandom_range(0, 31);
      issue(a, b);
    end

    begin
      int k;
      k = 0;
      while (exp_d.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    chk("drain", 64'(exp_d.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("dout_hold", out_dat, last_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_radix2_iter.md
# div_radix2_iter

Iterative unsigned radix-2 restoring divider that sits directly downstream of the multiply/divide ALU section. It accepts magnitude-only dividend/divisor operands over a joint valid/ready handshake and returns `{quotient, remainder}` after a fixed or (optionally) data-dependent number of cycles. Sign correction and division-by-zero overrides stay in the caller.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits; output is `2*WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `s_axis_dividend_tvalid`  in  1  dividend valid.
- `s_axis_dividend_tready`  out  1  dividend ready.
- `s_axis_dividend_tdata`  in  WIDTH  unsigned dividend.
- `s_axis_divisor_tvalid`  in  1  divisor valid.
- `s_axis_divisor_tready`  out  1  divisor ready; always equal to dividend ready.
- `s_axis_divisor_tdata`  in  WIDTH  unsigned divisor.
- `m_axis_dout_tvalid`  out  1  one-cycle result strobe; there is no output back-pressure.
- `m_axis_dout_tdata`  out  2*WIDTH  `[2W-1:W]` quotient, `[W-1:0]` remainder.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - Both treadys are 1.
  - Accept occurs only when both tvalids are 1 in the same cycle.
  - A single asserted tvalid is ignored: no transfer, no state change.
  - On accept, latch the operands: partial remainder = 0, quotient register = dividend, divisor register = divisor.
  - Load the iteration counter with N, then go to RUN.
- **RUN** (one step per cycle)
  - `{rem, quo} <<= 1`; `diff = rem_shifted - divisor` computed at `WIDTH+1` bits.
  - If `diff` is non-negative: `rem = diff` and `quo[0] = 1`; otherwise `rem` is kept and `quo[0] = 0`.
  - Decrement the counter; when it reaches 1 on a step, go to DONE after that step.
- **DONE**
  - `m_axis_dout_tvalid` = 1 for exactly this cycle; next state is IDLE.
  - Both treadys are 0.
- `m_axis_dout_tdata` is a register. It updates only on entry to DONE and then holds until the next DONE.
- Divisor 0 produces quotient = all ones and remainder = dividend, falling out of the algorithm with no special case. Example: `0x12345678 / 0` → `{0xFFFFFFFF, 0x12345678}`.
- Dividend less than divisor gives q = 0, r = dividend.
- Reset mid-operation: all state clears immediately, the in-flight operation is discarded, and no tvalid strobe is produced.

## Timing
- Reset values:
  - FSM = IDLE.
  - `m_axis_dout_tvalid` = 0.
  - `m_axis_dout_tdata` = 0.
  - Both treadys = 0 while `rstn` is low. Ready is a register set to 1 on the first rising edge after release.
- Treadys are 0 during RUN and DONE.
- Latency: accept in cycle T; N RUN cycles from T+1 to T+N; DONE and tvalid in cycle T+N+1.
  - Default N = WIDTH, giving tvalid at T+33.
- Throughput: the next accept is possible at T+N+2, i.e. one operation per N+2 cycles.

## Configuration
- Macro: `DIV_RADIX2_EARLY_OUT_EN`.
- **Defined:**
  - At accept, a leading-zero count `lz` of the dividend is computed.
  - The quotient register is loaded with `dividend << lz` and N = `WIDTH - lz`, clamped to a minimum of 1. A zero dividend gives N = 1.
  - If the divisor is 0, the skip is disabled and N = WIDTH so the all-ones quotient stays exact.
  - Results are bit-identical to the non-macro build; only latency differs.
- **Undefined:** N = WIDTH always, the leading-zero logic is absent, and latency is fixed.

## Structure
- Package `div_pkg`:
  - FSM state enum `div_state_t` (IDLE, RUN, DONE).
  - `DIV_WIDTH_DEFAULT` = 32.
  - Counter width constant `$clog2(WIDTH+1)`.
- Sub-module `div_lzc`:
  - Combinational leading-zero counter, `WIDTH` in → `$clog2(WIDTH+1)` out.
  - Instantiated only under `DIV_RADIX2_EARLY_OUT_EN`.

## Test plan
- `100 / 7`, non-macro build → tvalid at exactly T+33, dout = `{0x0000000E, 0x00000002}`, treadys 0 from T+1 to T+33 and 1 at T+34.
- `0xFFFFFFFF / 1` → `{0xFFFFFFFF, 0x00000000}`; `0x12345678 / 0` → `{0xFFFFFFFF, 0x12345678}` in both builds (macro build takes 33 cycles for the zero divisor).
- Dividend tvalid = 1 and divisor tvalid = 0 for 5 cycles in IDLE → no accept and no tvalid; raising the divisor tvalid then starts a normal operation.
- Reset: drop `rstn` at T+10 of `1000 / 3` → tvalid is never asserted, dout = 0, treadys are 0 while `rstn` is low and 1 on the first edge after release; a following `9 / 3` returns `{3, 0}`.
- Macro build, `5 / 3` → lz = 29, N = 3, tvalid at T+4, dout = `{1, 2}`; `0 / 7` → N = 1, tvalid at T+2, dout = `{0, 0}`.
- Back-to-back: random operand pairs issued as soon as ready → next accept at T+N+2, and each dout equals the `/` and `%` reference values; random-N coverage in the macro build.
